// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue stage for the ALU.
// Decodes one RV32I instruction into an ALU op select plus two operands and
// holds the result in a single-entry register. The handshake is valid/ready
// on both sides, with a flush that kills the held entry.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  out_rd,
    output logic        out_br,
    output logic        out_br_inv,
    output logic        out_illegal
);

    // ALU operation encodings
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One issued entry; the held register and the decoder share this shape.
    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        br;
        logic        br_inv;
        logic        illegal;
    } entry_t;

    entry_t dec;
    entry_t held;
    logic   vld;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt_i;
    logic [31:0] shamt_r;
    logic        accept;

    assign opcode  = in_inst[6:0];
    assign f3      = in_inst[14:12];
    assign f7      = in_inst[31:25];
    assign imm_i   = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_u   = {in_inst[31:12], 12'b0};
    assign shamt_i = {27'b0, in_inst[24:20]};
    assign shamt_r = {27'b0, in_rs2[4:0]};

    assign in_ready = !vld || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Map funct3 to the shared OP / OP-IMM operation; alt selects SUB/SRA.
    function automatic logic [4:0] arith_sel(input logic [2:0] fn3, input logic alt);
        logic [4:0] s;
        case (fn3)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

    // Decode the incoming instruction into an entry; illegal encodings
    // collapse to ADD with zero operands so EX sees a harmless op.
    always_comb begin
        dec         = '0;
        dec.sel     = ALU_ADD;
        dec.rd      = in_inst[11:7];
        dec.illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.a = in_rs1;
                if (f7 == F7_BASE) begin
                    dec.sel = arith_sel(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.sel = arith_sel(f3, 1'b1);
                end else begin
                    dec.illegal = 1'b1;
                end
                dec.b = (f3 == 3'b001 || f3 == 3'b101) ? shamt_r : in_rs2;
            end
            OPC_OP_IMM: begin
                dec.a = in_rs1;
                if (f3 == 3'b001) begin
                    dec.sel     = ALU_SLL;
                    dec.b       = shamt_i;
                    dec.illegal = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec.sel     = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec.b       = shamt_i;
                    dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                end else begin
                    // SUB has no immediate form
                    dec.sel = arith_sel(f3, 1'b0);
                    dec.b   = imm_i;
                end
            end
            OPC_LUI: begin
                dec.a = '0;
                dec.b = imm_u;
            end
            OPC_AUIPC: begin
                dec.a = in_pc;
                dec.b = imm_u;
            end
            OPC_LOAD: begin
                dec.a = in_rs1;
                dec.b = imm_i;
            end
            OPC_STORE: begin
                dec.a = in_rs1;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a      = in_rs1;
                dec.b      = in_rs2;
                dec.br     = 1'b1;
                dec.br_inv = f3[0];
                case (f3[2:1])
                    2'b00:   dec.sel = ALU_SUB;
                    2'b10:   dec.sel = ALU_SLT;
                    2'b11:   dec.sel = ALU_SLTU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.a = in_pc;
                dec.b = 32'd4;
            end
            OPC_JALR: begin
                dec.a       = in_pc;
                dec.b       = 32'd4;
                dec.illegal = (f3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.sel    = ALU_ADD;
            dec.a      = '0;
            dec.b      = '0;
            dec.br     = 1'b0;
            dec.br_inv = 1'b0;
        end
    end

    // Entry valid: reset beats flush, flush beats accept, accept beats drain.
    always_ff @(posedge clk) begin
        if (rst)
            vld <= 1'b0;
        else if (flush)
            vld <= 1'b0;
        else if (accept)
            vld <= 1'b1;
        else if (out_ready)
            vld <= 1'b0;
    end

    // Data register loads only on accept, so a stalled or empty entry is bit-stable.
    always_ff @(posedge clk) begin
        if (rst)
            held <= '0;
        else if (accept)
            held <= dec;
    end

    assign out_valid   = vld;
    assign alu_sel     = held.sel;
    assign alu_a       = held.a;
    assign alu_b       = held.b;
    assign out_rd      = held.rd;
    assign out_br      = held.br;
    assign out_br_inv  = held.br_inv;
    assign out_illegal = held.illegal;

endmodule
